// File: rtl/wb_uart_tx.sv
// Wishbone B3 slave UART transmitter: byte FIFO feeding an 8N1 serialiser,
// with status/divisor registers and a drained-FIFO interrupt level.
module wb_uart_tx #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic [15:0]     divisor, eff_div, div_lat, baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [31:0]     rdata;
  logic [7:0]      count_field;
  logic [1:0]      reg_idx;
  logic            access, wr_access, push_req, push_ok, pop;
  logic            full, empty, baud_done;
  logic            unused_bits;

  assign unused_bits = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0],
                         wb_dat_i[31:16], wb_sel_i[3:2]};

  assign reg_idx     = wb_adr_i[3:2];
  assign access      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_access   = access & wb_we_i;
  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign pop         = (state == S_IDLE) && !empty;
  assign push_req    = wr_access && (reg_idx == 2'd0) && wb_sel_i[0];
  // A full FIFO still accepts a push when the transmitter pops on the same edge.
  assign push_ok     = push_req && (!full || pop);
  assign eff_div     = (divisor == 16'd0) ? 16'd1 : divisor;
  assign baud_done   = (baud_cnt == div_lat - 16'd1);
  assign count_field = 8'(count);

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    rdata = '0;
    case (reg_idx)
      2'd1:    rdata = {16'b0, count_field, 4'b0, overflow, empty, full, state != S_IDLE};
      2'd2:    rdata = {16'b0, divisor};
      default: rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      divisor  <= 16'(CLK_DIV);
      irq_o    <= 1'b1;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= access ? rdata : '0;
      irq_o    <= empty && (state == S_IDLE);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop)
        overflow <= 1'b1;
      else if (wr_access && reg_idx == 2'd1 && wb_sel_i[0] && wb_dat_i[3])
        overflow <= 1'b0;
      if (wr_access && reg_idx == 2'd2) begin
        if (wb_sel_i[0]) divisor[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) divisor[15:8] <= wb_dat_i[15:8];
      end
    end
  end

  // NOTE: the storage array has no reset; emptiness is defined by the pointers/count.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= wb_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!empty) state_next = S_START;
      S_START: if (baud_done) state_next = S_DATA;
      S_DATA:  if (baud_done && bit_cnt == 3'd7) state_next = S_STOP;
      S_STOP:  if (baud_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_o = 1'b1;
    case (state)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shift[0];
      default: tx_o = 1'b1;
    endcase
  end

  // The divisor is latched at the pop so mid-frame DIVISOR writes wait for the next frame.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      shift    <= '0;
      div_lat  <= 16'd1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (pop) begin
      shift    <= mem[rd_ptr];
      div_lat  <= eff_div;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state != S_IDLE) begin
      baud_cnt <= baud_done ? '0 : baud_cnt + 16'd1;
      if (state == S_DATA && baud_done) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: a queue/waveform model checked every cycle
// plus directed register and serial-pattern expectations.
module tb_wb_uart_tx;
  localparam int DEPTH = 16;
  localparam int DIV0  = 434;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        tx_o;
  logic        irq_o;

  wb_uart_tx #(.CLK_DIV(DIV0), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .tx_o(tx_o), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: byte queue plus the remaining per-cycle waveform of the frame on the line.
  logic [7:0]  m_q[$];
  bit          m_wave[$];
  bit          m_ovf = 1'b0;
  logic [15:0] m_div = 16'(DIV0);
  bit          m_ack = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          m_irq = 1'b1;
  bit          chk_en = 1'b0;

  always @(negedge wb_clk_i) begin
    bit         idle_pre, empty_pre, full_pre, popped, acc;
    int         n;
    logic [7:0] b;
    if (chk_en) begin
      check("tx_o", 32'(tx_o), (m_wave.size() != 0) ? 32'(m_wave[0]) : 32'd1);
      check("irq_o", 32'(irq_o), 32'(m_irq));
      check("ack", 32'(wb_ack_o), 32'(m_ack));
      check("dat_o", wb_dat_o, m_ack ? m_rdata : 32'd0);
    end
    if (wb_rst_i) begin
      m_q.delete();
      m_wave.delete();
      m_ovf = 1'b0; m_div = 16'(DIV0); m_ack = 1'b0; m_rdata = '0; m_irq = 1'b1;
    end else begin
      idle_pre  = (m_wave.size() == 0);
      empty_pre = (m_q.size() == 0);
      full_pre  = (m_q.size() == DEPTH);
      acc       = wb_cyc_i && wb_stb_i && !m_ack;
      if (acc) begin
        case (wb_adr_i[3:2])
          2'd1:    m_rdata = {16'b0, 8'(m_q.size()), 4'b0, m_ovf, empty_pre, full_pre, !idle_pre};
          2'd2:    m_rdata = {16'b0, m_div};
          default: m_rdata = 32'd0;
        endcase
      end
      popped = 1'b0;
      if (!idle_pre) begin
        void'(m_wave.pop_front());
      end else if (!empty_pre) begin
        b = m_q.pop_front();
        popped = 1'b1;
        n = (m_div == 16'd0) ? 1 : int'(m_div);
        for (int k = 0; k < n; k++) m_wave.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < n; k++) m_wave.push_back(b[i]);
        for (int k = 0; k < n; k++) m_wave.push_back(1'b1);
      end
      if (acc && wb_we_i) begin
        case (wb_adr_i[3:2])
          2'd0: if (wb_sel_i[0]) begin
                  if (full_pre && !popped) m_ovf = 1'b1;
                  else m_q.push_back(wb_dat_i[7:0]);
                end
          2'd1: if (wb_sel_i[0] && wb_dat_i[3]) m_ovf = 1'b0;
          2'd2: begin
                  if (wb_sel_i[0]) m_div[7:0]  = wb_dat_i[7:0];
                  if (wb_sel_i[1]) m_div[15:8] = wb_dat_i[15:8];
                end
          default: ;
        endcase
      end
      m_ack = acc;
      m_irq = empty_pre && idle_pre;
    end
  end

  // Bus tasks are entered 1 time unit after a rising edge.
  task automatic bus(input logic [1:0] idx, input logic we, input logic [31:0] d,
                     input logic [3:0] sel, output logic [31:0] rd, output int lat);
    bit got = 1'b0;
    rd = '0;
    lat = -1;
    wb_adr_i = 32'(idx) << 2;
    wb_dat_i = d;
    wb_sel_i = sel;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wb_ack_o) begin
        rd = wb_dat_o; lat = i; got = 1'b1;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r; int l;
    bus(idx, 1'b1, d, sel, r, l);
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] r);
    int l;
    bus(idx, 1'b0, 32'd0, 4'hF, r, l);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // Leaves the bench on the negedge of the first low START cycle.
  task automatic wait_tx_low(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge wb_clk_i);
      if (tx_o == 1'b0) begin found = 1'b1; break; end
    end
    if (!found) check("tx_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string name, input logic [7:0] data, input int div);
    logic [9:0] pat;
    pat = {1'b1, data, 1'b0};
    for (int i = 0; i < 10 * div; i++) begin
      check(name, 32'(tx_o), 32'(pat[i / div]));
      @(negedge wb_clk_i);
    end
    check({name, "_idle"}, 32'(tx_o), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          lat;
    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    chk_en   = 1'b1;

    // Reset state and register map
    bus(2'd1, 1'b0, 32'd0, 4'hF, r, lat);
    check("status_after_reset", r, 32'h0000_0004);
    check("ack_latency", 32'(lat), 32'd0);
    check("tx_idle", 32'(tx_o), 32'd1);
    check("irq_idle", 32'(irq_o), 32'd1);
    rd(2'd2, r);  check("divisor_reset", r, 32'd434);
    rd(2'd0, r);  check("txdata_read", r, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    rd(2'd3, r);  check("reg3_read", r, 32'd0);
    wr(2'd2, 32'h0000_00FF, 4'b0001);
    rd(2'd2, r);  check("divisor_lane0", r, 32'h0000_01FF);
    wr(2'd2, 32'h0000_0300, 4'b0010);
    rd(2'd2, r);  check("divisor_lane1", r, 32'h0000_03FF);

    // Single frame, divisor 4
    wr(2'd2, 32'd4, 4'b0011);
    wr(2'd0, 32'h55, 4'b0001);
    wait_tx_low(20);
    check_frame("frame_55", 8'h55, 4);
    @(posedge wb_clk_i); #1;
    cycles(2);
    check("irq_after_frame", 32'(irq_o), 32'd1);

    // Fill FIFO behind a slow frame, then overflow
    wr(2'd2, 32'd20, 4'b0011);
    for (int i = 0; i <= 16; i++) wr(2'd0, 32'(i), 4'b0001);
    rd(2'd1, r);  check("status_full_no_ovf", r, 32'h0000_1003);
    wr(2'd0, 32'h77, 4'b0001);
    rd(2'd1, r);  check("status_overflow", r, 32'h0000_100B);
    wr(2'd1, 32'h8, 4'b0001);
    rd(2'd1, r);  check("status_ovf_cleared", r, 32'h0000_1003);
    wr(2'd2, 32'd2, 4'b0011);
    cycles(700);
    rd(2'd1, r);  check("status_drained", r, 32'h0000_0004);
    check("irq_drained", 32'(irq_o), 32'd1);

    // Divisor 0 behaves as 1
    wr(2'd2, 32'd0, 4'b0011);
    wr(2'd0, 32'hA3, 4'b0001);
    wait_tx_low(10);
    check_frame("frame_a3", 8'hA3, 1);
    @(posedge wb_clk_i); #1;
    cycles(3);

    // Reset mid-DATA with bytes queued
    wr(2'd2, 32'd4, 4'b0011);
    wr(2'd0, 32'h11, 4'b0001);
    wr(2'd0, 32'h22, 4'b0001);
    wr(2'd0, 32'h33, 4'b0001);
    wr(2'd0, 32'h44, 4'b0001);
    rd(2'd1, r);  check("status_three_queued", r, 32'h0000_0301);
    cycles(4);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    check("tx_after_reset", 32'(tx_o), 32'd1);
    rd(2'd1, r);  check("status_after_mid_reset", r, 32'h0000_0004);
    cycles(100);
    check("tx_quiet_after_reset", 32'(tx_o), 32'd1);
    check("irq_after_reset", 32'(irq_o), 32'd1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
